// File: rtl/seg_scan_decoder_pkg.sv
// Shared glyph constants and types for the 7-segment scan decoder.
// Glyphs are active-high gfedcba so encoder and decoder share one table.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_DP = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLING,
        ST_HELD
    } settle_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph lookup: 7-bit active-high pattern to hex nibble.
// hit_o marks a hex glyph, blank_o an all-dark digit.
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        hit_o    = 1'b1;
        blank_o  = 1'b0;
        unique case (pattern_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: begin
                hit_o   = 1'b0;
                blank_o = 1'b1;
            end
            default:   hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex digits shown by a multiplexed 7-segment scan.
// Samples are synchronised, normalised, and captured once after settling.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              segment_in,
    input  logic [NUM_DIGITS-1:0]   enable_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update_strobe,
    output logic [1:0]              update_index,
    output logic                    pattern_err,
    output logic                    frame_done
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] EN_ONE  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] EN_ALL  = {NUM_DIGITS{1'b1}};

    logic [SW-1:0] sync1_q, sync2_q, prev_q;
    logic [SW-1:0] norm;
    logic [7:0]    seg_n;
    logic [NUM_DIGITS-1:0] en_n;

    settle_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          changed;
    logic          capture;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [NUM_DIGITS-1:0]   mask_set;
    logic                    strobe_q, strobe_d;
    logic [1:0]              idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    frame_q, frame_d;

    logic       one_hot;
    logic [1:0] en_idx;
    logic [3:0] nibble;
    logic       hit;
    logic       blank;

    assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~sync2_q[7:0] : sync2_q[7:0];
    assign en_n  = (EN_ACTIVE_LOW != 0) ? ~sync2_q[SW-1:8] : sync2_q[SW-1:8];
    assign norm  = {en_n, seg_n};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {enable_in, segment_in};
            sync2_q <= sync1_q;
            prev_q  <= norm;
        end
    end

    seg_pattern_decode u_dec (
        .pattern_i (norm[6:0]),
        .nibble_o  (nibble),
        .hit_o     (hit),
        .blank_o   (blank)
    );

    assign changed = (norm != prev_q);

    // Any change restarts settling, even on the cycle the count would finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (changed) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end
            end
            ST_SETTLING: begin
                if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = CNT_MAX;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (changed) begin
                    state_d = ST_SETTLING;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        one_hot = (en_n != '0) && ((en_n & (en_n - EN_ONE)) == '0);
        en_idx  = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_n[i]) begin
                en_idx = 2'(i);
            end
        end
    end

    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        frame_d  = 1'b0;
        mask_set = mask_q | en_n;
        // Blanking gaps (no or several enables) are ignored entirely.
        if (capture && one_hot) begin
            strobe_d = 1'b1;
            idx_d    = en_idx;
            if (mask_set == EN_ALL) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d = mask_set;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en_n[i]) begin
                    if (hit) begin
                        digits_d[4*i +: 4] = nibble;
                        dp_d[i]    = norm[SEG_DP];
                        valid_d[i] = 1'b1;
                    end else if (blank) begin
                        dp_d[i]    = norm[SEG_DP];
                        valid_d[i] = 1'b0;
                    end else begin
                        valid_d[i] = 1'b0;
                        err_d      = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            idx_q    <= 2'd0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            frame_q  <= frame_d;
        end
    end

    assign digits_out    = digits_q;
    assign dp_out        = dp_q;
    assign digit_valid   = valid_q;
    assign update_strobe = strobe_q;
    assign update_index  = idx_q;
    assign pattern_err   = err_q;
    assign frame_done    = frame_q;

endmodule
